dmem_copy_engine: RTL
=====================

# dmem_copy_engine

Block-transfer initiator that sits on the DMEM port in place of the datapath during bulk memory operations. It issues read and write requests to DMEM to copy a run of words from one address to another, or to fill a run with a constant. It drives DMEM's address, data-in, write and read inputs and consumes DMEM's combinational data-out. Used for stack/array initialisation and buffer moves without CPU involvement; the top level muxes DMEM ownership on `DCE_busy`.

## Interface
- `ADDR_WIDTH`, 8, DMEM word-address width; addresses wrap modulo 2^ADDR_WIDTH
- `DATA_WIDTH`, 32, DMEM word width
- `DCE_clk`  in  1  clock; DMEM is clocked by the same clock, writes on posedge
- `DCE_reset`  in  1  synchronous, active-high reset
- `DCE_start`  in  1  request pulse; sampled only in IDLE
- `DCE_mode`  in  1  0 = copy, 1 = fill; latched on start
- `DCE_src`  in  ADDR_WIDTH  copy source base; latched on start
- `DCE_dst`  in  ADDR_WIDTH  destination base; latched on start
- `DCE_len`  in  ADDR_WIDTH+1  word count, 0..256; latched on start
- `DCE_fill_value`  in  DATA_WIDTH  fill word; latched on start
- `DCE_busy`  out  1  high in every state except IDLE
- `DCE_done`  out  1  one-cycle completion pulse
- `DCE_count`  out  ADDR_WIDTH+1  words written in the current/last transfer
- `DCE_mem_address`  out  ADDR_WIDTH  to DMEM address
- `DCE_mem_data_out`  out  DATA_WIDTH  to DMEM data-in
- `DCE_mem_write`  out  1  to DMEM write enable
- `DCE_mem_read`  out  1  to DMEM read enable
- `DCE_mem_data_in`  in  DATA_WIDTH  from DMEM data-out; combinational, valid in the same cycle as `DCE_mem_read`

## Operation
- States: IDLE, READ, WRITE, DONE. Registered state; memory-side outputs decoded from state and registers only (no input-to-output paths).
- IDLE: all memory outputs 0. On `DCE_start`, latch operands, clear count, load `src_ptr`/`dst_ptr`/`remaining`. Next state: len=0 -> DONE; mode=copy -> READ; mode=fill -> WRITE.
- READ: address=`src_ptr`, read=1, write=0. At the edge, capture `DCE_mem_data_in` into `data_reg` and increment `src_ptr`. Next state: WRITE.
- WRITE: address=`dst_ptr`, write=1, read=0. Data-out=`data_reg` (copy) or the latched fill value (fill). At the edge: `dst_ptr`+1, count+1, remaining−1. If remaining was 1 -> DONE; else copy -> READ, fill -> WRITE.
- DONE: done=1 and busy=1 for exactly one cycle; memory outputs 0. Next state: IDLE.
- `DCE_start` is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Pointers increment modulo 2^ADDR_WIDTH: address 255 -> 0.
- Copy runs strictly ascending. For overlapping regions with dst > src, already-written words are re-read. Example: src=0, dst=1, len=3 replicates word 0 into words 1..3. This is the defined behaviour.
- `DCE_count` holds its final value after DONE until the next accepted start.
- `DCE_mem_data_out` is 0 whenever write=0.

## Timing
- Reset, at any state: next cycle is IDLE, busy=0, done=0, count=0, pointers/data_reg=0, all memory outputs 0.
- A WRITE cycle whose closing edge coincides with reset still commits in DMEM. No further accesses follow.
- Start accepted at edge e0. Copy: first READ is the cycle after e0, 2 cycles per word, done high in cycle 2N+1 after e0. Fill: 1 cycle per word, done in cycle N+1. len=0: done in cycle 1, no memory access.
- A start asserted in the DONE cycle is ignored. A start in the following (IDLE) cycle is accepted.
- Throughput: copy 1 word/2 cycles; fill 1 word/cycle.

## Test plan
- Copy: preload DMEM[10..13]=A,B,C,D; start copy src=10, dst=40, len=4. Required: DMEM[40..43]=A,B,C,D; done exactly 9 cycles after the start edge; count=4; DMEM[10..13] unchanged.
- Fill wrap: start fill dst=254, len=4, value=0xDEADBEEF. Required: DMEM[254], [255], [0], [1]=0xDEADBEEF; done 5 cycles after start; DMEM[2] untouched.
- Zero length: start len=0. Required: no read/write asserted; done pulse 1 cycle after start; count=0.
- Full length: copy src=0, dst=0, len=256. Required: 256 writes, memory unchanged, count=256, done at cycle 513.
- Busy behaviour: mid-transfer start pulse with different operands -> ignored, original result intact. Start in the DONE cycle -> ignored. Start one cycle later -> accepted.
- Reset mid-op: assert reset after 2 of 6 fill words. Required: next cycle IDLE with all outputs 0; only DMEM[dst], [dst+1] written; no done pulse.

Source files
------------

// File: rtl/dmem_copy_engine_if.sv
// DMEM port bundle between the copy engine (master) and the data memory (slave).
// Read data returns combinationally in the same cycle as the read request.
interface dmem_copy_engine_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] DCE_mem_address;
   logic [DATA_WIDTH-1:0] DCE_mem_data_out;
   logic                  DCE_mem_write;
   logic                  DCE_mem_read;
   logic [DATA_WIDTH-1:0] DCE_mem_data_in;

   modport master (
      output DCE_mem_address,
      output DCE_mem_data_out,
      output DCE_mem_write,
      output DCE_mem_read,
      input  DCE_mem_data_in
   );

   modport slave (
      input  DCE_mem_address,
      input  DCE_mem_data_out,
      input  DCE_mem_write,
      input  DCE_mem_read,
      output DCE_mem_data_in
   );
endinterface

// File: rtl/dmem_copy_engine.sv
// Block copy / fill engine that owns the DMEM port while DCE_busy is high.
// Copy alternates READ/WRITE per word; fill issues back-to-back WRITEs.
module dmem_copy_engine #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  DCE_clk,
   input  logic                  DCE_reset,
   input  logic                  DCE_start,
   input  logic                  DCE_mode,
   input  logic [ADDR_WIDTH-1:0] DCE_src,
   input  logic [ADDR_WIDTH-1:0] DCE_dst,
   input  logic [ADDR_WIDTH:0]   DCE_len,
   input  logic [DATA_WIDTH-1:0] DCE_fill_value,
   output logic                  DCE_busy,
   output logic                  DCE_done,
   output logic [ADDR_WIDTH:0]   DCE_count,
   dmem_copy_engine_if.master    mem_bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   ONE_L  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   ZERO_L = '0;

   state_t                r_state;
   logic                  r_mode;
   logic [ADDR_WIDTH-1:0] r_src_ptr;
   logic [ADDR_WIDTH-1:0] r_dst_ptr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_fill;
   logic                  r_busy;
   logic                  r_done;

   always_ff @(posedge DCE_clk) begin
      if (DCE_reset) begin
         r_state     <= S_IDLE;
         r_mode      <= 1'b0;
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_count     <= '0;
         r_data      <= '0;
         r_fill      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (DCE_start) begin
                  r_mode      <= DCE_mode;
                  r_src_ptr   <= DCE_src;
                  r_dst_ptr   <= DCE_dst;
                  r_remaining <= DCE_len;
                  r_fill      <= DCE_fill_value;
                  r_count     <= '0;
                  r_busy      <= 1'b1;
                  if (DCE_len == ZERO_L) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (DCE_mode) begin
                     r_state <= S_WRITE;
                  end else begin
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_data    <= mem_bus.DCE_mem_data_in;
               r_src_ptr <= r_src_ptr + ONE_A;
               r_state   <= S_WRITE;
            end
            S_WRITE: begin
               r_dst_ptr   <= r_dst_ptr + ONE_A;
               r_count     <= r_count + ONE_L;
               r_remaining <= r_remaining - ONE_L;
               // remaining is checked before the decrement lands: 1 means this is the last word
               if (r_remaining == ONE_L) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (r_mode) begin
                  r_state <= S_WRITE;
               end else begin
                  r_state <= S_READ;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Memory side is a pure decode of registered state, so data_out is 0 outside WRITE
   always_comb begin
      mem_bus.DCE_mem_address  = '0;
      mem_bus.DCE_mem_data_out = '0;
      mem_bus.DCE_mem_write    = 1'b0;
      mem_bus.DCE_mem_read     = 1'b0;
      case (r_state)
         S_READ: begin
            mem_bus.DCE_mem_address = r_src_ptr;
            mem_bus.DCE_mem_read    = 1'b1;
         end
         S_WRITE: begin
            mem_bus.DCE_mem_address  = r_dst_ptr;
            mem_bus.DCE_mem_write    = 1'b1;
            mem_bus.DCE_mem_data_out = r_mode ? r_fill : r_data;
         end
         default: begin
            mem_bus.DCE_mem_address = '0;
         end
      endcase
   end

   assign DCE_busy  = r_busy;
   assign DCE_done  = r_done;
   assign DCE_count = r_count;

endmodule
